// File: rtl/safe_path_scan_ctrl.sv
// rtl/safe_path_scan_ctrl.sv - bounded, handshaked first-delimiter scanner that sanitises a packed path string
//
// Accepts one packed string per request and scans it BYTES_PER_CYC bytes per
// beat, starting at byte 0. The result is the string with the first delimiter
// and every later byte zeroed, plus the index of that delimiter.
//
// Ports:
//   clk        clock
//   areset_n   asynchronous active-low reset
//   in_valid   request valid
//   in_ready   engine idle, request can be accepted
//   in_path    packed string, byte b = in_path[8*b +: 8]
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   out_path   sanitised string
//   out_len    index of first delimiter, or STR_BYTES if none
//   out_found  a delimiter was present
//
// Build option: define SAFE_PATH_SCAN_BACKSLASH_EN to make 8'h5C a delimiter
// with the same priority as DELIM.
module safe_path_scan_ctrl #(
    parameter int         STR_BYTES     = 512,
    parameter int         BYTES_PER_CYC = 8,
    parameter logic [7:0] DELIM         = 8'h2F
) (
    input  logic                               clk,
    input  logic                               areset_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [8*STR_BYTES-1:0]             in_path,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [8*STR_BYTES-1:0]             out_path,
    output logic [$clog2(STR_BYTES+1)-1:0]     out_len,
    output logic                               out_found
);

    localparam int BEATS = STR_BYTES / BYTES_PER_CYC;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = $clog2(STR_BYTES + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [8*STR_BYTES-1:0] work_q;
    logic [8*STR_BYTES-1:0] work_cut;
    logic [BW-1:0]          beat_q;
    logic                   hit;
    logic [LW-1:0]          hit_idx;
    logic                   last_beat;

    function automatic logic is_delim(input logic [7:0] b);
`ifdef SAFE_PATH_SCAN_BACKSLASH_EN
        return (b == DELIM) || (b == 8'h5C);
`else
        return (b == DELIM);
`endif
    endfunction

    // Walk lanes from highest to lowest so the lowest matching lane is the
    // one left in hit_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int l = BYTES_PER_CYC - 1; l >= 0; l--) begin
            if (is_delim(work_q[(int'(beat_q) * BYTES_PER_CYC + l) * 8 +: 8])) begin
                hit     = 1'b1;
                hit_idx = LW'(int'(beat_q) * BYTES_PER_CYC + l);
            end
        end
    end

    // Clear the delimiter byte and everything above it.
    always_comb begin
        work_cut = work_q;
        for (int b = 0; b < STR_BYTES; b++) begin
            if (LW'(b) >= hit_idx) begin
                work_cut[b*8 +: 8] = 8'h00;
            end
        end
    end

    assign last_beat = (beat_q == BW'(BEATS - 1));

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit || last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Return to IDLE only; acceptance of a new request waits a cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            work_q    <= '0;
            beat_q    <= '0;
            out_len   <= '0;
            out_found <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_path;
                        beat_q <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        work_q    <= work_cut;
                        out_len   <= hit_idx;
                        out_found <= 1'b1;
                    end else if (last_beat) begin
                        out_len   <= LW'(STR_BYTES);
                        out_found <= 1'b0;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The working register is only rewritten on acceptance and on the final
    // scan edge, so it is stable for the whole time out_valid is high.
    assign out_path = work_q;

endmodule

// File: tb/tb_safe_path_scan_ctrl.sv
// tb/tb_safe_path_scan_ctrl.sv - directed self-checking bench for safe_path_scan_ctrl
module tb_safe_path_scan_ctrl;

    localparam int SB = 512;
    localparam int W  = 8 * SB;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          areset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_path;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_path;
    logic [LW-1:0] out_len;
    logic          out_found;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    safe_path_scan_ctrl dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_path   (in_path),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_path  (out_path),
        .out_len   (out_len),
        .out_found (out_found)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] fill(input logic [7:0] v);
        logic [W-1:0] r;
        for (int b = 0; b < SB; b++) r[b*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] cut(input logic [W-1:0] p, input int k);
        logic [W-1:0] r;
        r = p;
        for (int b = k; b < SB; b++) r[b*8 +: 8] = 8'h00;
        return r;
    endfunction

    // Index of the first differing byte, SB when identical.
    function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] e);
        for (int b = 0; b < SB; b++) begin
            if (a[b*8 +: 8] !== e[b*8 +: 8]) return b;
        end
        return SB;
    endfunction

    task automatic send(input string tag, input logic [W-1:0] p);
        check({tag, "_rdy_before"}, 32'(in_ready), 1);
        in_path  = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_rdy_after"}, 32'(in_ready), 0);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, 32'(out_valid), 0);
        check({tag, "_rdy_back"}, 32'(in_ready), 1);
    endtask

    task automatic run(input string tag, input logic [W-1:0] p, input int exp_len,
                       input int exp_found, input int exp_lat, input logic [W-1:0] exp_path);
        int lat;
        send(tag, p);
        wait_out(lat);
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_len"},   32'(out_len), 32'(exp_len));
        check({tag, "_found"}, 32'(out_found), 32'(exp_found));
        check({tag, "_path"},  32'(first_diff(out_path, exp_path)), SB);
        take(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] p;
        logic [W-1:0] p2;
        int lat;
        int vld_seen;
        int exp_bs;

        areset_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_path   = '0;
        #2;
        check("rst_in_ready",  32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_len",   32'(out_len), 0);
        check("rst_out_found", 32'(out_found), 0);
        check("rst_out_path",  32'(first_diff(out_path, '0)), SB);
        tick();
        tick();
        areset_n = 1'b1;
        tick();
        check("idle_in_ready",  32'(in_ready), 1);
        check("idle_out_valid", 32'(out_valid), 0);
        check("idle_out_len",   32'(out_len), 0);

        // "abc/def" then 0x41 filler
        p = fill(8'h41);
        p[0*8 +: 8] = "a"; p[1*8 +: 8] = "b"; p[2*8 +: 8] = "c"; p[3*8 +: 8] = "/";
        p[4*8 +: 8] = "d"; p[5*8 +: 8] = "e"; p[6*8 +: 8] = "f";
        run("abc", p, 3, 1, 1, cut(p, 3));

        // No delimiter anywhere
        p = fill(8'h41);
        run("nodelim", p, SB, 0, SB / 8, p);

        // Delimiter only in the top byte
        p = fill(8'h41);
        p[511*8 +: 8] = "/";
        run("top", p, 511, 1, SB / 8, cut(p, 511));

        // "/" at bytes 0 and 100; out_ready held low; in_valid held with a new path
        p  = fill(8'h41);
        p[0*8 +: 8]   = "/";
        p[100*8 +: 8] = "/";
        p2 = fill(8'h41);
        p2[20*8 +: 8] = "/";
        in_path  = p;
        in_valid = 1'b1;
        tick();
        in_path = p2;
        wait_out(lat);
        check("b0_lat",   32'(lat), 1);
        check("b0_len",   32'(out_len), 0);
        check("b0_found", 32'(out_found), 1);
        check("b0_path",  32'(first_diff(out_path, '0)), SB);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_vld",  32'(out_valid), 1);
            check("hold_len",  32'(out_len), 0);
            check("hold_path", 32'(first_diff(out_path, '0)), SB);
            check("hold_rdy",  32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_vld_drop", 32'(out_valid), 0);
        check("hs_no_bypass_rdy", 32'(in_ready), 1);
        tick();
        check("held_req_taken", 32'(in_ready), 0);
        in_valid = 1'b0;
        wait_out(lat);
        check("held_lat",   32'(lat), 3);
        check("held_len",   32'(out_len), 20);
        check("held_found", 32'(out_found), 1);
        check("held_path",  32'(first_diff(out_path, cut(p2, 20))), SB);
        take("held");

        // Reset in the middle of a scan
        p = fill(8'h41);
        p[300*8 +: 8] = "/";
        send("mid", p);
        for (int i = 0; i < 10; i++) tick();
        areset_n = 1'b0;
        #2;
        check("mid_rst_rdy",   32'(in_ready), 1);
        check("mid_rst_vld",   32'(out_valid), 0);
        check("mid_rst_len",   32'(out_len), 0);
        check("mid_rst_found", 32'(out_found), 0);
        tick();
        areset_n = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid) vld_seen++;
        end
        check("mid_no_result", 32'(vld_seen), 0);
        run("after_rst", p, 300, 1, 38, cut(p, 300));

        // "a", backslash, "b", slash, "c" then filler
        p = fill(8'h41);
        p[0*8 +: 8] = "a"; p[1*8 +: 8] = 8'h5C; p[2*8 +: 8] = "b";
        p[3*8 +: 8] = "/"; p[4*8 +: 8] = "c";
`ifdef SAFE_PATH_SCAN_BACKSLASH_EN
        exp_bs = 1;
`else
        exp_bs = 3;
`endif
        run("bslash", p, exp_bs, 1, 1, cut(p, exp_bs));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
